// File: rtl/clk_sel_capture_arb.sv
// clk_sel_capture_arb: round-robin capture arbiter with mode-gated eligibility and post-grant hold window
module clk_sel_capture_arb #(
    parameter int DW = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mode,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] din,
    output logic [3:0]      ack,
    output logic [DW-1:0]   q,
    output logic            q_valid,
    output logic [1:0]      q_src,
    output logic            busy
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state;
    logic [1:0] ptr, off, win;
    logic [3:0] cnt, mask, elig;
    logic [2:0] rot;
    assign mask = mode == 2'b11 ? 4'b1010 : mode == 2'b10 ? 4'b0000 : 4'b1111;
    assign elig = req & mask;
    // rot[k] is the eligibility of requester ptr+k; bit 3 is implied when the first three are clear
    assign rot = ptr == 2'd0 ? elig[2:0] : ptr == 2'd1 ? elig[3:1] : ptr == 2'd2 ? {elig[0], elig[3:2]} : {elig[1:0], elig[3]};
    assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign win = ptr + off;
    assign busy = state == HOLD;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            cnt <= '0;
            q <= '0;
            q_src <= '0;
            ack <= '0;
            q_valid <= 1'b0;
        end else begin
            ack <= '0;
            q_valid <= 1'b0;
            if (state == IDLE && elig != 4'b0) begin
                q <= din[win*DW +: DW];
                q_src <= win;
                ack <= 4'b0001 << win;
                q_valid <= 1'b1;
                ptr <= win + 2'd1;
                cnt <= 4'(HOLD_CYCLES);
                state <= HOLD;
            end else if (state == HOLD) begin
                if (cnt == 4'd0) state <= IDLE;
                else cnt <= cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_clk_sel_capture_arb.sv
// tb_clk_sel_capture_arb: scenario tasks plus randomized run against a behavioural arbiter model.
// Instance a uses HOLD_CYCLES=2, instance b HOLD_CYCLES=0; both see the same stimulus.
module tb_clk_sel_capture_arb;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] mode = '0;
    logic [3:0] req = '0;
    logic [4*DW-1:0] din = '0;
    logic [3:0] ack_a, ack_b;
    logic [DW-1:0] q_a, q_b;
    logic qv_a, qv_b, busy_a, busy_b;
    logic [1:0] src_a, src_b;
    int n_vec = 0;
    int n_err = 0;
    int m_ptr[2];
    int m_left[2];
    logic [3:0] m_ack[2];
    logic [DW-1:0] m_q[2];
    logic m_qv[2];
    logic [1:0] m_src[2];

    always #5 clk = ~clk;

    clk_sel_capture_arb #(.DW(DW), .HOLD_CYCLES(2)) u_a (
        .clk(clk), .reset(reset), .mode(mode), .req(req), .din(din),
        .ack(ack_a), .q(q_a), .q_valid(qv_a), .q_src(src_a), .busy(busy_a));
    clk_sel_capture_arb #(.DW(DW), .HOLD_CYCLES(0)) u_b (
        .clk(clk), .reset(reset), .mode(mode), .req(req), .din(din),
        .ack(ack_b), .q(q_b), .q_valid(qv_b), .q_src(src_b), .busy(busy_b));

    function automatic bit eligible(input logic [1:0] md, input int n);
        return md == 2'b10 ? 1'b0 : md == 2'b11 ? (n % 2 == 1) : 1'b1;
    endfunction

    // m_left counts remaining hold cycles including the current one; zero means idle
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int won;
            won = -1;
            m_ack[i] = '0;
            m_qv[i] = 1'b0;
            if (reset) begin
                m_ptr[i] = 0;
                m_left[i] = 0;
                m_q[i] = '0;
                m_src[i] = '0;
            end else if (m_left[i] > 0) begin
                m_left[i]--;
            end else begin
                for (int j = 0; j < 4; j++)
                    if (won < 0 && req[(m_ptr[i] + j) % 4] && eligible(mode, (m_ptr[i] + j) % 4))
                        won = (m_ptr[i] + j) % 4;
                if (won >= 0) begin
                    m_q[i] = din[won*DW +: DW];
                    m_src[i] = 2'(won);
                    m_ack[i] = 4'(1 << won);
                    m_qv[i] = 1'b1;
                    m_ptr[i] = (won + 1) % 4;
                    m_left[i] = (i == 0 ? 2 : 0) + 1;
                end
            end
        end
    end

    function automatic logic [15:0] obs(input int i);
        return i == 0 ? {ack_a, q_a, qv_a, src_a, busy_a} : {ack_b, q_b, qv_b, src_b, busy_b};
    endfunction

    function automatic logic [15:0] exp_of(input int i);
        return {m_ack[i], m_q[i], m_qv[i], m_src[i], m_left[i] != 0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        mode = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (obs(0) !== 16'h0) begin n_err++; $display("FAIL reset_a got %h want 0000", obs(0)); end
        n_vec++;
        if (obs(1) !== 16'h0) begin n_err++; $display("FAIL reset_b got %h want 0000", obs(1)); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int nbusy;
        do_reset();
        din[7:0] = 8'hA5;
        req = 4'b0001;
        @(negedge clk);
        n_vec++;
        if (obs(0) !== {4'b0001, 8'hA5, 1'b1, 2'd0, 1'b1}) begin
            n_err++; $display("FAIL single_grant got %h want %h", obs(0), {4'b0001, 8'hA5, 1'b1, 2'd0, 1'b1});
        end
        req = '0;
        nbusy = 1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            nbusy += int'(busy_a);
            n_vec++;
            if (obs(0) !== exp_of(0)) begin n_err++; $display("FAIL single_model got %h want %h", obs(0), exp_of(0)); end
        end
        n_vec++;
        if (nbusy != 3) begin n_err++; $display("FAIL single_busy_len got %0d want 3", nbusy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq[$];
        int at[$];
        logic [3:0] e_ord[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        din = {$urandom};
        req = 4'hF;
        for (int t = 0; t < 40 && seq.size() < 5; t++) begin
            @(negedge clk);
            n_vec++;
            if (obs(0) !== exp_of(0)) begin n_err++; $display("FAIL rr_model t=%0d got %h want %h", t, obs(0), exp_of(0)); end
            if (ack_a != 0) begin
                seq.push_back(ack_a);
                at.push_back(t);
                req = req & ~ack_a;
            end else req = 4'hF;
        end
        req = '0;
        n_vec++;
        if (seq.size() != 5) begin n_err++; $display("FAIL rr_count got %0d want 5", seq.size()); end
        for (int k = 0; k < seq.size(); k++) begin
            n_vec++;
            if (seq[k] !== e_ord[k]) begin n_err++; $display("FAIL rr_order k=%0d got %b want %b", k, seq[k], e_ord[k]); end
            if (k > 0) begin
                n_vec++;
                if (at[k] - at[k-1] != 4) begin n_err++; $display("FAIL rr_spacing k=%0d got %0d want 4", k, at[k] - at[k-1]); end
            end
        end
    endtask

    task automatic test_mode11();
        do_reset();
        din = {$urandom};
        mode = 2'b11;
        req = 4'b0101;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            n_vec++;
            if ({ack_a, busy_a} !== 5'b0) begin n_err++; $display("FAIL mode11_idle t=%0d got ack=%b busy=%b want 0", t, ack_a, busy_a); end
        end
        req = 4'b1101;
        @(negedge clk);
        n_vec++;
        if ({ack_a, q_a, src_a} !== {4'b1000, din[31:24], 2'd3}) begin
            n_err++; $display("FAIL mode11_grant got %h want %h", {ack_a, q_a, src_a}, {4'b1000, din[31:24], 2'd3});
        end
        req = '0;
    endtask

    task automatic test_frozen();
        do_reset();
        din = {$urandom};
        mode = 2'b10;
        req = 4'hF;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            n_vec++;
            if (ack_a !== 4'b0) begin n_err++; $display("FAIL frozen_ack t=%0d got %b want 0000", t, ack_a); end
        end
        mode = 2'b00;
        @(negedge clk);
        n_vec++;
        if (ack_a !== 4'b0001) begin n_err++; $display("FAIL frozen_release got %b want 0001", ack_a); end
        req = '0;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        din = {$urandom};
        req = 4'b0100;
        @(negedge clk);
        n_vec++;
        if (ack_a !== 4'b0100) begin n_err++; $display("FAIL rst_hold_grant got %b want 0100", ack_a); end
        req = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (obs(0) !== 16'h0) begin n_err++; $display("FAIL rst_hold_clear got %h want 0000", obs(0)); end
        reset = 1'b0;
        req = 4'b0110;
        @(negedge clk);
        n_vec++;
        if ({ack_a, q_a, src_a} !== {4'b0010, din[15:8], 2'd1}) begin
            n_err++; $display("FAIL rst_hold_next got %h want %h", {ack_a, q_a, src_a}, {4'b0010, din[15:8], 2'd1});
        end
        do_reset();
        reset = 1'b1;
        req = 4'b0001;
        @(negedge clk);
        n_vec++;
        if ({ack_a, busy_a} !== 5'b0) begin n_err++; $display("FAIL rst_coincident got ack=%b busy=%b want 0", ack_a, busy_a); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ack_a !== 4'b0001) begin n_err++; $display("FAIL rst_after got %b want 0001", ack_a); end
        req = '0;
    endtask

    task automatic test_hold0();
        logic [3:0] e;
        do_reset();
        din = {$urandom};
        req = 4'b0100;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            e = (t % 2 == 0) ? 4'b0100 : 4'b0000;
            n_vec++;
            if ({ack_b, qv_b} !== {e, e != 0}) begin n_err++; $display("FAIL hold0_pulse t=%0d got %b/%b want %b", t, ack_b, qv_b, e); end
            n_vec++;
            if (obs(1) !== exp_of(1)) begin n_err++; $display("FAIL hold0_model t=%0d got %h want %h", t, obs(1), exp_of(1)); end
        end
        req = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (obs(i) !== exp_of(i)) begin n_err++; $display("FAIL random_model inst=%0d t=%0d got %h want %h", i, t, obs(i), exp_of(i)); end
            end
            reset = $urandom_range(0, 49) == 0;
            mode = 2'($urandom);
            req = 4'($urandom);
            din = {$urandom};
        end
        reset = 1'b0;
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mode11();
        test_frozen();
        test_reset_mid_hold();
        test_hold0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
